// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg: shared master ids and bus field widths for bus_arb_2m
package bus_arb_pkg;
  typedef logic [0:0] m_id_t;
  localparam m_id_t M_UDM = 1'b0;
  localparam m_id_t M_CPU = 1'b1;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W = 4;
endpackage

// File: rtl/bus_arb_idfifo.sv
// bus_arb_idfifo: in-order master-id FIFO (push/pop/full/empty/count, async active-low reset arst_n_i)
module bus_arb_idfifo
  import bus_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             arst_n_i,
  input  logic             push,
  input  logic             pop,
  input  m_id_t            din,
  output m_id_t            dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  logic [DEPTH-1:0] mem;
  logic [PW-1:0] wp, rp;
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      mem <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= wp + PW'(1);
      end
      if (pop) rp <= rp + PW'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  assign dout = m_id_t'(mem[rp]);
  assign full = count == CNT_W'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/bus_arb_2m.sv
// bus_arb_2m: two-master (UDM=0, CPU=1) to one-slave arbiter with in-order read routing; BUS_ARB_RR_EN selects round-robin over fixed priority
module bus_arb_2m
  import bus_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_bi,
  input  logic [DATA_W-1:0] m0_wdata_bi,
  input  logic [BE_W-1:0]   m0_be_bi,
  output logic              m0_ack_o,
  output logic              m0_resp_o,
  output logic [DATA_W-1:0] m0_rdata_bo,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_bi,
  input  logic [DATA_W-1:0] m1_wdata_bi,
  input  logic [BE_W-1:0]   m1_be_bi,
  output logic              m1_ack_o,
  output logic              m1_resp_o,
  output logic [DATA_W-1:0] m1_rdata_bo,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_bo,
  output logic [DATA_W-1:0] s_wdata_bo,
  output logic [BE_W-1:0]   s_be_bo,
  input  logic              s_ack_i,
  input  logic              s_resp_i,
  input  logic [DATA_W-1:0] s_rdata_bi,
  output logic [CNT_W-1:0]  outstanding_o,
  output logic              err_o
);
  logic full, empty, elig0, elig1, any, push, pop;
  m_id_t gnt, last_grant, head;
  assign elig0 = m0_req_i & (m0_we_i | ~full);
  assign elig1 = m1_req_i & (m1_we_i | ~full);
  assign any = elig0 | elig1;
`ifdef BUS_ARB_RR_EN
  assign gnt = (elig0 & elig1) ? ~last_grant : (elig1 ? M_CPU : M_UDM);
`else
  assign gnt = elig0 ? M_UDM : (elig1 ? M_CPU : last_grant);
`endif
  always_comb begin
    s_req_o = any;
    s_we_o = any & (gnt == M_CPU ? m1_we_i : m0_we_i);
    s_addr_bo = any ? (gnt == M_CPU ? m1_addr_bi : m0_addr_bi) : '0;
    s_wdata_bo = any ? (gnt == M_CPU ? m1_wdata_bi : m0_wdata_bi) : '0;
    s_be_bo = any ? (gnt == M_CPU ? m1_be_bi : m0_be_bi) : '0;
    m0_ack_o = any & (gnt == M_UDM) & s_ack_i;
    m1_ack_o = any & (gnt == M_CPU) & s_ack_i;
    push = s_req_o & s_ack_i & ~s_we_o;
    pop = s_resp_i & ~empty;
    m0_resp_o = pop & (head == M_UDM);
    m1_resp_o = pop & (head == M_CPU);
    m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
    m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;
  end
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      last_grant <= M_CPU;
      err_o <= 1'b0;
    end else begin
      if (s_req_o & s_ack_i) last_grant <= gnt;
      if (s_resp_i & empty) err_o <= 1'b1;
    end
  end
  bus_arb_idfifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_idfifo (
    .clk_i(clk_i),
    .arst_n_i(arst_n_i),
    .push(push),
    .pop(pop),
    .din(gnt),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(outstanding_o)
  );
endmodule

// File: tb/tb_bus_arb_2m.sv
// tb_bus_arb_2m: directed self-checking bench for bus_arb_2m
module tb_bus_arb_2m;
  logic clk_i = 1'b0, arst_n_i = 1'b0;
  logic m0_req, m0_we, m0_ack, m0_resp, m1_req, m1_we, m1_ack, m1_resp;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
  logic [3:0] m0_be, m1_be, s_be;
  logic s_req, s_we, s_ack, s_resp, err;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [2:0] outstanding;
  int n_chk = 0, n_fail = 0;
  always #5 clk_i = ~clk_i;
  bus_arb_2m dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_wdata_bi(m0_wdata), .m0_be_bi(m0_be),
    .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_wdata_bi(m1_wdata), .m1_be_bi(m1_be),
    .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
    .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_wdata_bo(s_wdata), .s_be_bo(s_be),
    .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
    .outstanding_o(outstanding), .err_o(err)
  );
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask
  initial begin
    {m0_req, m0_we, m1_req, m1_we, s_ack, s_resp} = '0;
    {m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata} = '0;
    m0_be = 4'hf;
    m1_be = 4'h3;
    #3;
    chk("rst_outstanding", 32'(outstanding), 0);
    chk("rst_err", 32'(err), 0);
    chk("idle_s_req", 32'(s_req), 0);
    chk("idle_s_be", 32'(s_be), 0);
    chk("idle_m0_ack", 32'(m0_ack), 0);
    step();
    arst_n_i = 1'b1;
    step();
    m1_req = 1; m1_we = 0; m1_addr = 32'h10; s_ack = 1;
    #2;
    chk("rd1_s_req", 32'(s_req), 1);
    chk("rd1_s_addr", s_addr, 32'h10);
    chk("rd1_s_be", 32'(s_be), 32'h3);
    chk("rd1_m1_ack", 32'(m1_ack), 1);
    chk("rd1_m0_ack", 32'(m0_ack), 0);
    step();
    m1_req = 0;
    #2;
    chk("rd1_out1", 32'(outstanding), 1);
    step();
    s_resp = 1; s_rdata = 32'hDEADBEEF;
    #2;
    chk("rd1_m1_resp", 32'(m1_resp), 1);
    chk("rd1_m1_rdata", m1_rdata, 32'hDEADBEEF);
    chk("rd1_m0_resp", 32'(m0_resp), 0);
    chk("rd1_m0_rdata", m0_rdata, 0);
    step();
    s_resp = 0;
    #2;
    chk("rd1_out0", 32'(outstanding), 0);
    m0_req = 1; m0_we = 1; m0_addr = 32'hA0; m1_req = 1; m1_we = 1; m1_addr = 32'hB0;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef BUS_ARB_RR_EN
      chk("arb_m0_ack", 32'(m0_ack), (k % 2 == 0) ? 1 : 0);
      chk("arb_m1_ack", 32'(m1_ack), (k % 2 == 0) ? 0 : 1);
`else
      chk("arb_m0_ack", 32'(m0_ack), 1);
      chk("arb_m1_ack", 32'(m1_ack), 0);
`endif
      step();
    end
    m0_req = 0; m1_req = 0;
    step();
    m0_req = 1; m0_we = 0; m0_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("fill_m0_ack", 32'(m0_ack), 1);
      step();
    end
    #2;
    chk("full_out", 32'(outstanding), 4);
    chk("full_m0_ack", 32'(m0_ack), 0);
    chk("full_s_req", 32'(s_req), 0);
    m1_req = 1; m1_we = 1; m1_wdata = 32'hCAFE;
    #1;
    chk("full_wr_ack", 32'(m1_ack), 1);
    chk("full_wr_we", 32'(s_we), 1);
    chk("full_wr_wdata", s_wdata, 32'hCAFE);
    step();
    m1_req = 0; s_resp = 1; s_rdata = 32'h55;
    #2;
    chk("fullpop_m0_resp", 32'(m0_resp), 1);
    chk("fullpop_m0_rdata", m0_rdata, 32'h55);
    chk("fullpop_m0_ack", 32'(m0_ack), 0);
    step();
    s_resp = 0;
    #2;
    chk("after_pop_out", 32'(outstanding), 3);
    chk("fifth_m0_ack", 32'(m0_ack), 1);
    step();
    m0_req = 0;
    #2;
    chk("refill_out", 32'(outstanding), 4);
    s_resp = 1;
    for (int k = 0; k < 4; k++) step();
    s_resp = 0;
    #2;
    chk("drain_out", 32'(outstanding), 0);
    chk("drain_err", 32'(err), 0);
    m0_req = 1; m0_we = 0;
    step();
    m0_req = 0; m1_req = 1; m1_we = 0;
    step();
    m1_req = 0; m0_req = 1;
    step();
    m0_req = 0;
    #2;
    chk("ord_out", 32'(outstanding), 3);
    s_resp = 1; s_rdata = 32'h1;
    #1;
    chk("ord1_m0_resp", 32'(m0_resp), 1);
    chk("ord1_m0_rdata", m0_rdata, 32'h1);
    chk("ord1_m1_resp", 32'(m1_resp), 0);
    step();
    s_rdata = 32'h2;
    #1;
    chk("ord2_m1_resp", 32'(m1_resp), 1);
    chk("ord2_m1_rdata", m1_rdata, 32'h2);
    chk("ord2_m0_resp", 32'(m0_resp), 0);
    step();
    s_rdata = 32'h3;
    #1;
    chk("ord3_m0_resp", 32'(m0_resp), 1);
    chk("ord3_m0_rdata", m0_rdata, 32'h3);
    step();
    s_resp = 0; m1_req = 1; m1_we = 0;
    step();
    step();
    m1_req = 0;
    #2;
    chk("pp_pre_out", 32'(outstanding), 2);
    m0_req = 1; m0_we = 0; s_resp = 1; s_rdata = 32'h77;
    #1;
    chk("pp_m0_ack", 32'(m0_ack), 1);
    chk("pp_m1_resp", 32'(m1_resp), 1);
    chk("pp_m1_rdata", m1_rdata, 32'h77);
    step();
    m0_req = 0; s_resp = 0;
    #2;
    chk("pp_out", 32'(outstanding), 2);
    arst_n_i = 0;
    #1;
    chk("async_rst_out", 32'(outstanding), 0);
    step();
    arst_n_i = 1;
    step();
    s_resp = 1; s_rdata = 32'h99;
    #2;
    chk("orphan_m0_resp", 32'(m0_resp), 0);
    chk("orphan_m1_resp", 32'(m1_resp), 0);
    step();
    s_resp = 0;
    #2;
    chk("orphan_err", 32'(err), 1);
    step();
    chk("orphan_err_sticky", 32'(err), 1);
    arst_n_i = 0;
    #1;
    chk("err_cleared", 32'(err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bus_arb_2m.md
Name: bus_arb_2m

Overview:
- Two-master to one-slave bus arbiter on the shared data bus.
- Master 0 is the UDM debug bus; master 1 is the CPU data port. The slave is the bus unit's data-side port.
- Replaces ad-hoc single-outstanding muxing with arbitration plus in-order response routing through an ID FIFO, so each master may have several reads in flight.
- Bus protocol is req/we/addr/be/wdata, with ack in the request cycle and a later resp carrying rdata. Only reads produce a resp.

Parameters:
- DEPTH, 4, maximum outstanding reads tracked (power of two, 2..16).
- CNT_W, $clog2(DEPTH+1), width of the outstanding-read counter.

Ports:
- clk_i  in  1  clock.
- arst_n_i  in  1  reset, asynchronous, active-low.
- m0_req_i, m0_we_i  in  1 each  master 0 request, write enable.
- m0_addr_bi, m0_wdata_bi  in  32 each  master 0 address, write data.
- m0_be_bi  in  4  master 0 byte enables.
- m0_ack_o, m0_resp_o  out  1 each  master 0 accept, read response valid.
- m0_rdata_bo  out  32  master 0 read data.
- m1_*  same set as m0_*  master 1 (CPU data).
- s_req_o, s_we_o  out  1 each  slave request, write enable.
- s_addr_bo, s_wdata_bo  out  32 each  slave address, write data.
- s_be_bo  out  4  slave byte enables.
- s_ack_i, s_resp_i  in  1 each  slave accept, read response valid.
- s_rdata_bi  in  32  slave read data.
- outstanding_o  out  CNT_W  current FIFO occupancy.
- err_o  out  1  sticky: a resp arrived with no outstanding read.

Behaviour:
Clocking and reset:
- One clock domain, clk_i. Reset is arst_n_i, asynchronous, active-low.
- Reset state: FIFO empty, outstanding_o = 0, err_o = 0, last_grant = 1 (so master 0 wins first).
- With no requests, all s_* and m*_ack_o/resp_o/rdata outputs are 0.

Request path (combinational):
- A master is eligible when its req is high and either (a) we = 1, or (b) we = 0 and the FIFO is not full. A read while the FIFO is full is stalled: no grant and no ack.
- Grant with both masters eligible: round-robin, the master not in last_grant wins. Otherwise the single eligible master wins.
- The granted master's req/we/addr/be/wdata drive s_*. Other s_* outputs are 0.
- s_ack_i is returned only to the granted master's ack. The other master's ack is 0.
- A master must hold its request stable until acked. The grant may change between cycles while the slave withholds ack; this is legal because nothing was accepted.

State updates:
- Accepted transfer = s_req_o & s_ack_i. On it, last_grant <= granted id. Unaccepted cycles leave last_grant unchanged.
- Push: an accepted read (s_we_o = 0) pushes the granted id into the FIFO.
- Pop: s_resp_i with the FIFO non-empty pops the head id. s_resp_i and s_rdata_bi route combinationally to that master's resp/rdata; the other master gets 0.
- Push and pop in the same cycle: both happen and occupancy is unchanged. Full-and-pop still blocks the new read that cycle; eligibility uses the registered full flag.
- Resp with the FIFO empty: dropped, no master resp, err_o <= 1 (sticky until reset). A read's resp may arrive no earlier than the cycle after its ack.
- outstanding_o = registered count.
- Pointers wrap modulo DEPTH.
- Mid-operation reset drops all tracked reads. Responses arriving after reset for pre-reset reads set err_o.
- Writes never touch the FIFO. Write acceptance is independent of FIFO state.

Optional Feature:
- Macro BUS_ARB_RR_EN.
- Defined: round-robin as described.
- Undefined: fixed priority, master 0 always wins when eligible. last_grant is still maintained but ignored.
- The response FIFO behaviour is identical in both builds.

Decomposition:
- Shared package bus_arb_pkg: master-id typedef (1 bit), constants M_UDM = 0 and M_CPU = 1, bus field widths (ADDR_W = 32, DATA_W = 32, BE_W = 4).
- One sub-module, bus_arb_idfifo: synchronous FIFO with parameter DEPTH, 1-bit entries, push/pop/full/empty/count, async active-low reset.
- Grant logic and muxing stay in the top.

Test Plan:
- M1 read at addr 0x10: ack cycle t, resp cycle t+2 with rdata 0xDEADBEEF -> m1_resp_o = 1 with 0xDEADBEEF at t+2, m0_resp_o = 0, outstanding 1 -> 0.
- Both masters request continuously, RR build -> accepted grants alternate 0,1,0,1. Fixed build -> master 0 always granted until it drops req.
- Four reads accepted without resp (DEPTH = 4), then a fifth read -> no ack, outstanding_o = 4. A write from the other master is still acked. After one resp the fifth read is acked.
- Reads accepted in order m0, m1, m0; responses 0x1, 0x2, 0x3 -> delivered to m0, m1, m0 respectively.
- s_resp_i pulse with the FIFO empty -> no master resp, err_o = 1 and held until arst_n_i low.
- Push and pop in the same cycle at occupancy 2 -> occupancy stays 2; arst_n_i asserted mid-burst -> outstanding_o = 0 immediately (asynchronous).
